// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: shared types and sizing helpers for the edge event arbiter
package edge_evt_pkg;
  localparam int DEF_NUM_CH = 4;
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int DEF_CH_W = ch_w(DEF_NUM_CH);
  typedef enum logic {EDGE_FALL = 1'b0, EDGE_RISE = 1'b1} edge_type_e;
  typedef struct packed {
    logic [DEF_CH_W-1:0] ch;
    edge_type_e          typ;
  } edge_evt_t;
endpackage

// File: rtl/edge_det_ch.sv
// edge_det_ch: one channel's edge detector, single-entry pending slot and sticky overflow
module edge_det_ch
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       prime_i,
  input  logic       a_i,
  input  logic       rise_en_i,
  input  logic       fall_en_i,
  input  logic       grant_i,
  input  logic       clr_ovf_i,
  output logic       pend_o,
  output edge_type_e typ_o,
  output logic       ovf_o
);
  logic       a_q, pend_q, pend_d, ovf_q, ovf_d, rise, fall, hit;
  edge_type_e typ_q, typ_d;
  always_comb begin
    rise   = prime_i & a_i & ~a_q & rise_en_i;
    fall   = prime_i & ~a_i & a_q & fall_en_i;
    hit    = (rise | fall) & pend_q & ~grant_i;
    pend_d = rise | fall | (pend_q & ~grant_i);
    typ_d  = ((rise | fall) & ~hit) ? edge_type_e'(rise) : typ_q;
    ovf_d  = hit | (ovf_q & ~clr_ovf_i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= 1'b0;
      pend_q <= 1'b0;
      typ_q  <= EDGE_FALL;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_i;
      pend_q <= pend_d;
      typ_q  <= typ_d;
      ovf_q  <= ovf_d;
    end
  end
  assign pend_o = pend_q;
  assign typ_o  = typ_q;
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge capture, round-robin grant onto one valid/ready event port
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int  NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a_i,
  input  logic [NUM_CH-1:0] rise_en_i,
  input  logic [NUM_CH-1:0] fall_en_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic              evt_rise_o,
  output logic [NUM_CH-1:0] overflow_o,
  input  logic [NUM_CH-1:0] clr_ovf_i
);
  logic              prime_q, valid_q, valid_d, found, load;
  logic [NUM_CH-1:0] pend, grant;
  logic [CH_W-1:0]   ptr_q, ptr_d, ch_q, ch_d, win, idx;
  edge_type_e        typ [NUM_CH];
  edge_type_e        typ_q, typ_d;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    load    = ~valid_q | evt_ready_i;
    grant   = (load & found) ? NUM_CH'(1) << win : '0;
    valid_d = load ? found : valid_q;
    ch_d    = (load & found) ? win : ch_q;
    typ_d   = (load & found) ? typ[win] : typ_q;
    ptr_d   = (load & found) ? ((int'(win) == NUM_CH - 1) ? '0 : win + 1'b1) : ptr_q;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    edge_det_ch u_ch (
      .clk       (clk),
      .reset     (reset),
      .prime_i   (prime_q),
      .a_i       (a_i[c]),
      .rise_en_i (rise_en_i[c]),
      .fall_en_i (fall_en_i[c]),
      .grant_i   (grant[c]),
      .clr_ovf_i (clr_ovf_i[c]),
      .pend_o    (pend[c]),
      .typ_o     (typ[c]),
      .ovf_o     (overflow_o[c])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q <= 1'b0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      ch_q    <= '0;
      typ_q   <= EDGE_FALL;
    end else begin
      prime_q <= 1'b1;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      typ_q   <= typ_d;
    end
  end
  assign evt_valid_o = valid_q;
  assign evt_ch_o    = ch_q;
  assign evt_rise_o  = (typ_q == EDGE_RISE);
endmodule
